// File: rtl/spi_pkg.sv
// Shared types and default geometry for the SPI burst slave.
package spi_pkg;

  localparam int DEF_ADDR_W      = 6;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int HDR_LEN         = 2 + DEF_ADDR_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2,
    DRAIN  = 2'd3
  } spi_state_e;

  // Header is rw bit, parity bit, then the address.
  function automatic int hdr_len(input int addr_w);
    return 2 + addr_w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous SPI pin with rise/fall pulses.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Resetting to 0 means a cs_n held low through reset must go high
  // before a new frame can start.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync[0] <= i_async;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/spi_burst_slave.sv
// SPI mode-0 register-access slave: rw/parity/address header followed by
// one or more data words, with optional address auto-increment.
module spi_burst_slave
  import spi_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int BURST_EN    = 1,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              spi_clk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic [ADDR_W-1:0] address,
  output logic              write_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              read_en,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              parity_err,
  output logic [7:0]        err_count
);

  localparam int HLEN  = hdr_len(ADDR_W);
  localparam int MAXL  = (HLEN > DATA_W) ? HLEN : DATA_W;
  localparam int SR_W  = MAXL - 1;
  localparam int CNT_W = $clog2(MAXL);
  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HLEN - 1);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(DATA_W - 1);

  logic w_sck_lvl, w_sck_rise, w_sck_fall;
  logic w_cs_lvl, w_cs_rise, w_cs_fall;
  logic w_mosi, w_mosi_rise, w_mosi_fall;
  logic w_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
    .clock(clock), .reset_n(reset_n), .i_async(spi_clk),
    .o_level(w_sck_lvl), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clock(clock), .reset_n(reset_n), .i_async(cs_n),
    .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clock(clock), .reset_n(reset_n), .i_async(mosi),
    .o_level(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
  );

  assign w_unused = &{1'b0, w_sck_lvl, w_cs_lvl, w_mosi_rise, w_mosi_fall};

  spi_state_e        r_state, w_next;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [SR_W-1:0]   r_shift;
  logic              r_rw, r_hdr_x, r_first, r_rd_load, r_miso;
  logic [DATA_W-1:0] r_tx;

  logic [SR_W-1:0]   w_shift_nx;
  logic [HLEN-1:0]   w_hdr;
  logic [DATA_W-1:0] w_word;
  logic              w_word_end, w_par_bad;

  assign w_shift_nx = {r_shift[SR_W-2:0], w_mosi};
  assign w_hdr      = {r_shift[HLEN-2:0], w_mosi};
  assign w_word     = {r_shift[DATA_W-2:0], w_mosi};
  assign w_word_end = (r_state == DATA) && w_sck_rise && (r_bit_cnt == WORD_LAST);
  assign w_par_bad  = r_hdr_x ^ (^w_word);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Read frames keep streaming through a parity failure; only writes drain.
  always_comb begin
    w_next = r_state;
    if (w_cs_rise) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_cs_fall) w_next = HEADER;
        HEADER:  if (w_sck_rise && (r_bit_cnt == HDR_LAST)) w_next = DATA;
        DATA:    if (w_word_end && r_first && ((w_par_bad && !r_rw) || (BURST_EN == 0)))
                   w_next = DRAIN;
        default: w_next = r_state;
      endcase
    end
  end

  always_comb begin
    busy = (r_state != IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_rw       <= 1'b0;
      r_hdr_x    <= 1'b0;
      r_first    <= 1'b0;
      r_rd_load  <= 1'b0;
      r_miso     <= 1'b0;
      r_tx       <= '0;
      address    <= '0;
      write_en   <= 1'b0;
      wr_data    <= '0;
      read_en    <= 1'b0;
      parity_err <= 1'b0;
      err_count  <= '0;
    end else begin
      write_en  <= 1'b0;
      read_en   <= 1'b0;
      r_rd_load <= read_en;
      // Write address advances once the strobe cycle is over.
      if (write_en && (BURST_EN != 0)) address <= address + ADDR_W'(1);
      case (r_state)
        IDLE: begin
          r_miso <= 1'b0;
          if (w_cs_fall) begin
            parity_err <= 1'b0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_first    <= 1'b1;
          end
        end
        HEADER: begin
          if (w_sck_rise) begin
            r_shift <= w_shift_nx;
            if (r_bit_cnt == HDR_LAST) begin
              r_bit_cnt <= '0;
              r_rw      <= w_hdr[HLEN-1];
              r_hdr_x   <= ^w_hdr;
              address   <= w_hdr[ADDR_W-1:0];
              read_en   <= w_hdr[HLEN-1];
            end else begin
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
          end
        end
        DATA: begin
          if (w_sck_rise) begin
            r_shift <= w_shift_nx;
            if (r_bit_cnt == WORD_LAST) begin
              r_bit_cnt <= '0;
              r_first   <= 1'b0;
              if (r_first && w_par_bad) begin
                parity_err <= 1'b1;
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
              end
              if (r_rw) begin
                if (BURST_EN != 0) begin
                  read_en <= 1'b1;
                  address <= address + ADDR_W'(1);
                end
              end else if (!(r_first && w_par_bad)) begin
                write_en <= 1'b1;
                wr_data  <= w_word;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
          end
          if (w_sck_fall && r_rw) begin
            r_miso <= r_tx[DATA_W-1];
            r_tx   <= r_tx << 1;
          end
        end
        default: ;
      endcase
      if (r_rd_load) r_tx <= rd_data;
      if (w_cs_rise) r_miso <= 1'b0;
    end
  end

  assign miso = r_miso & ~cs_n;

endmodule

// File: tb/tb_spi_burst_slave.sv
// Randomised frame-level bench for spi_burst_slave against a transaction model.
`timescale 1ns/1ps
module tb_spi_burst_slave;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;
  localparam int HLEN   = 2 + ADDR_W;
  localparam int HALF   = 6;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              spi_clk = 1'b0;
  logic              cs_n = 1'b1;
  logic              mosi = 1'b0;
  logic              miso, write_en, read_en, busy, parity_err;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data = '0;
  logic [7:0]        err_count;

  always #5 clock = ~clock;

  spi_burst_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_EN(1), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset_n(reset_n), .spi_clk(spi_clk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .address(address), .write_en(write_en), .wr_data(wr_data),
    .read_en(read_en), .rd_data(rd_data), .busy(busy), .parity_err(parity_err),
    .err_count(err_count)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] mem [64];
  int obs_wr[$], obs_rd[$], exp_wr[$], exp_rd[$];
  bit tx_bits[$], rx_bits[$];
  bit exp_perr = 1'b0;
  int exp_errcnt = 0;

  // Register-file model: logs strobes and returns data one clock after read_en.
  always @(negedge clock) begin
    if (reset_n && write_en) obs_wr.push_back(int'({address, wr_data}));
    if (reset_n && read_en) begin
      obs_rd.push_back(int'(address));
      rd_data = mem[address];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic spi_run(input int nbits, input bit raise_cs);
    cs_n = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < nbits; i++) begin
      mosi = tx_bits[i];
      wait_clk(HALF);
      rx_bits.push_back(miso);
      spi_clk = 1'b1;
      wait_clk(HALF);
      spi_clk = 1'b0;
    end
    wait_clk(2 * HALF);
    check_eq("busy_in_frame", busy, 1);
    if (raise_cs) begin
      cs_n = 1'b1;
      mosi = 1'b0;
      wait_clk(2 * HALF);
    end
  endtask

  // wN < 0 selects a random word; nbits_lim < 0 sends the whole frame.
  task automatic run_frame(input bit rw, input logic [5:0] addr, input int nwords,
                           input bit bad_par, input int nbits_lim, input bit raise_cs,
                           input int w0, input int w1, input int w2);
    logic [7:0] words[$];
    logic [7:0] b;
    int nbits, full, wsel;
    bit par;
    tx_bits.delete(); rx_bits.delete();
    obs_wr.delete(); obs_rd.delete(); exp_wr.delete(); exp_rd.delete();
    for (int k = 0; k < nwords; k++) begin
      wsel = (k == 0) ? w0 : (k == 1) ? w1 : w2;
      words.push_back((wsel >= 0) ? 8'(wsel) : 8'($urandom_range(0, 255)));
    end
    par = rw ^ (^addr) ^ (^words[0]) ^ bad_par;
    tx_bits.push_back(rw);
    tx_bits.push_back(par);
    for (int j = 5; j >= 0; j--) tx_bits.push_back(addr[j]);
    for (int k = 0; k < nwords; k++)
      for (int j = 7; j >= 0; j--) tx_bits.push_back(words[k][j]);
    nbits = (nbits_lim < 0) ? tx_bits.size() : nbits_lim;

    exp_perr = 1'b0;
    full = (nbits >= HLEN) ? (nbits - HLEN) / DATA_W : 0;
    if (full >= 1 && bad_par) begin
      exp_perr = 1'b1;
      if (exp_errcnt < 255) exp_errcnt++;
    end
    if (rw && nbits >= HLEN) begin
      exp_rd.push_back(int'(addr));
      for (int k = 0; k < full; k++) exp_rd.push_back((int'(addr) + k + 1) % 64);
    end
    if (!rw && !bad_par)
      for (int k = 0; k < full; k++)
        exp_wr.push_back((((int'(addr) + k) % 64) << 8) | int'(words[k]));

    spi_run(nbits, raise_cs);

    check_eq("wr_count", obs_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size(); i++)
      check_eq($sformatf("wr[%0d]", i), (i < obs_wr.size()) ? obs_wr[i] : -1, exp_wr[i]);
    check_eq("rd_count", obs_rd.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size(); i++)
      check_eq($sformatf("rd_addr[%0d]", i), (i < obs_rd.size()) ? obs_rd[i] : -1, exp_rd[i]);
    if (rw)
      for (int k = 0; k < full; k++) begin
        for (int j = 0; j < 8; j++) b[7-j] = rx_bits[HLEN + 8*k + j];
        check_eq($sformatf("miso_word[%0d]", k), b, mem[(int'(addr) + k) % 64]);
      end
    check_eq("parity_err", parity_err, exp_perr);
    check_eq("err_count", err_count, exp_errcnt);
    if (raise_cs) begin
      check_eq("busy_after", busy, 0);
      check_eq("miso_cs_high", miso, 0);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_miso"}, miso, 0);
    check_eq({pfx, "_address"}, address, 0);
    check_eq({pfx, "_write_en"}, write_en, 0);
    check_eq({pfx, "_wr_data"}, wr_data, 0);
    check_eq({pfx, "_read_en"}, read_en, 0);
    check_eq({pfx, "_busy"}, busy, 0);
    check_eq({pfx, "_parity_err"}, parity_err, 0);
    check_eq({pfx, "_err_count"}, err_count, 0);
  endtask

  initial begin
    bit rw, bad;
    int nw, lim;
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[4] = 8'h56;

    wait_clk(3);
    check_all_zero("reset");
    reset_n = 1'b1;
    wait_clk(4);

    run_frame(1'b0, 6'h04, 1, 1'b0, -1, 1'b1, 8'h56, -1, -1);   // single write
    run_frame(1'b1, 6'h04, 1, 1'b0, -1, 1'b1, -1, -1, -1);      // single read
    run_frame(1'b0, 6'h04, 1, 1'b1, -1, 1'b1, 8'h56, -1, -1);   // parity error
    run_frame(1'b0, 6'h3E, 3, 1'b0, -1, 1'b1, 8'h11, 8'h22, 8'h33); // wrapping burst
    run_frame(1'b0, 6'h10, 1, 1'b0, 12, 1'b1, -1, -1, -1);      // cs_n raised mid-word
    run_frame(1'b1, 6'h3F, 3, 1'b0, -1, 1'b1, -1, -1, -1);      // wrapping read burst

    for (int n = 0; n < 12; n++) begin
      rw  = 1'($urandom_range(0, 1));
      nw  = $urandom_range(1, 3);
      bad = !rw && ($urandom_range(0, 4) == 0);
      lim = ($urandom_range(0, 3) == 0) ? $urandom_range(1, HLEN + nw * DATA_W - 1) : -1;
      run_frame(rw, 6'($urandom_range(0, 63)), nw, bad, lim, 1'b1, -1, -1, -1);
    end

    // Reset in the middle of the third word of a burst, cs_n still low.
    run_frame(1'b0, 6'h20, 3, 1'b0, HLEN + 2 * DATA_W + 4, 1'b0, -1, -1, -1);
    reset_n = 1'b0;
    wait_clk(2);
    check_all_zero("midreset");
    exp_errcnt = 0;
    exp_perr   = 1'b0;
    reset_n = 1'b1;
    wait_clk(2);
    cs_n = 1'b1;
    mosi = 1'b0;
    wait_clk(2 * HALF);
    check_eq("post_reset_busy", busy, 0);
    run_frame(1'b0, 6'h21, 2, 1'b0, -1, 1'b1, -1, -1, -1);
    run_frame(1'b1, 6'h21, 2, 1'b0, -1, 1'b1, -1, -1, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_burst_slave.md
SPI_BURST_SLAVE -- requirements
Module: spi_burst_slave

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 6, meaning register address width in bits.
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning data word width in bits.
REQ-003 The block SHALL have parameter BURST_EN, default 1, meaning 1 enables auto-increment multi-word frames.
REQ-004 The block SHALL have parameter SYNC_STAGES, default 2, meaning synchroniser depth for spi_clk, cs_n and mosi.
REQ-005 The block SHALL have port clock, input, 1 bit, the main clock.
REQ-006 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port spi_clk, input, 1 bit, SPI clock (mode 0).
REQ-008 The block SHALL have port cs_n, input, 1 bit, active-low chip select.
REQ-009 The block SHALL have port mosi, input, 1 bit, master out slave in.
REQ-010 The block SHALL have port miso, output, 1 bit, master in slave out.
REQ-011 The block SHALL have port address, output, ADDR_W bits, register-file address.
REQ-012 The block SHALL have port write_en, output, 1 bit, one-clock write strobe.
REQ-013 The block SHALL have port wr_data, output, DATA_W bits, write data.
REQ-014 The block SHALL have port read_en, output, 1 bit, one-clock read strobe.
REQ-015 The block SHALL have port rd_data, input, DATA_W bits, read data, valid 1 clock after read_en.
REQ-016 The block SHALL have port busy, output, 1 bit, high while a frame is in progress.
REQ-017 The block SHALL have port parity_err, output, 1 bit, sticky parity-failure flag for the current/last frame.
REQ-018 The block SHALL have port err_count, output, 8 bits, saturating count of parity failures.

Function
REQ-019 All SPI inputs SHALL be sampled in the clock domain through SYNC_STAGES flops; clock SHALL be at least 8x spi_clk.
REQ-020 Frame format SHALL be MSB first: rw (1=read), parity, address[ADDR_W-1:0], then DATA_W-bit data words.
REQ-021 mosi SHALL be sampled on the detected spi_clk rising edge; miso SHALL change only on the detected falling edge.
REQ-022 Parity SHALL pass when the XOR of rw, parity, address and the first data word equals 0.
REQ-023 The state machine SHALL have states IDLE, HEADER, DATA and DRAIN: IDLE->HEADER on cs_n fall; HEADER->DATA after 2+ADDR_W bits; DATA->DRAIN on parity fail or after the first word when BURST_EN=0; any state->IDLE on cs_n rise.
REQ-024 For reads, read_en SHALL pulse 1 clock after the last header bit, rd_data SHALL be latched 1 clock later, and the word SHALL drive miso from the next falling edge, MSB first.
REQ-025 For writes, write_en SHALL pulse for one clock, with address and wr_data stable, 1 clock after the final bit of each word, and only if parity passed.
REQ-026 In burst mode, address SHALL increment by 1 after each word, wrapping modulo 2^ADDR_W.
REQ-027 In burst mode, the next read_en SHALL pulse when the last bit of the current word is sampled.
REQ-028 A parity failure SHALL suppress every write in the frame, set parity_err, and increment err_count (saturating at 255).
REQ-029 Reads under a parity failure SHALL complete normally, since they have no side effects.
REQ-030 parity_err SHALL clear on the next cs_n fall.
REQ-031 A cs_n rise mid-word SHALL discard the partial word with no write_en; miso SHALL be 0 when cs_n is high.
REQ-032 busy SHALL be high from the detected cs_n fall until the detected cs_n rise.

Reset
REQ-033 On reset_n low, all outputs SHALL be 0 (miso, address, write_en, wr_data, read_en, busy, parity_err, err_count), state SHALL be IDLE, and shift registers SHALL be cleared.
REQ-034 Reset mid-frame SHALL abort the frame with no write; the block SHALL wait for a fresh cs_n fall.

Structure
REQ-035 Package spi_pkg SHALL hold the state enumeration, default width constants and the header length (2+ADDR_W).
REQ-036 Sub-module spi_sync_edge SHALL implement the synchroniser plus rise/fall detection, instantiated per SPI input.

Verification
REQ-037 Write: rw=0, addr 0x04, data 0x56, correct parity -> one write_en, address=0x04, wr_data=0x56.
REQ-038 Read: rw=1, addr 0x04, rd_data=0x56 -> exactly one read_en with address=0x04; miso shifts 0x56 MSB first.
REQ-039 Parity error: addr 0x04, data 0x56, parity bit inverted -> no write_en, parity_err=1, err_count=1.
REQ-040 Burst write at 0x3E with words 0x11, 0x22, 0x33 -> writes to 0x3E, 0x3F, 0x00 with those data.
REQ-041 cs_n raised after 12 bits of a write frame -> no write_en, busy falls, state IDLE.
REQ-042 reset_n pulsed low mid-burst -> all outputs 0; the next complete frame is processed normally.
